test_pattern_gen: RTL

Pixel source feeding the HDMI encoder. It consumes the encoder's `row`/`column` scan coordinates and produces 8-bit `r`/`g`/`b` through a fixed 2-cycle pipeline. It offers four selectable patterns, including an animated bouncing box whose position updates once per frame. The pattern mode changes only on frame boundaries, so the picture never tears.

---
 rtl/pattern_pkg.sv | 43 ++++
 rtl/box_axis.sv | 39 +++
 rtl/test_pattern_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, colour constants and bar lookup for the test pattern source
package pattern_pkg;

   typedef enum logic [1:0] {
      GRADIENT = 2'd0,
      BARS     = 2'd1,
      CHECKER  = 2'd2,
      BOX      = 2'd3
   } pattern_mode_e;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
   localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
   localparam logic [23:0] C_CYAN    = 24'h00FFFF;
   localparam logic [23:0] C_GREEN   = 24'h00FF00;
   localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
   localparam logic [23:0] C_RED     = 24'hFF0000;
   localparam logic [23:0] C_BLUE    = 24'h0000FF;
   localparam logic [23:0] C_BLACK   = 24'h000000;
   localparam logic [23:0] C_BOX_BG  = 24'h000040;

   function automatic rgb_t bar_color(input logic [2:0] idx);
      logic [23:0] c;
      c = C_BLACK;
      case (idx)
         3'd0: c = C_WHITE;
         3'd1: c = C_YELLOW;
         3'd2: c = C_CYAN;
         3'd3: c = C_GREEN;
         3'd4: c = C_MAGENTA;
         3'd5: c = C_RED;
         3'd6: c = C_BLUE;
         default: c = C_BLACK;
      endcase
      return rgb_t'(c);
   endfunction

endpackage

// File: rtl/box_axis.sv
// rtl/box_axis.sv - one axis of the bouncing box: position ping-pongs between 0 and LIMIT
module box_axis #(
   parameter int LIMIT = 1216,
   parameter int WIDTH = 11
) (
   input  logic             pix_clk,
   input  logic             reset_n,
   input  logic             step,
   output logic [WIDTH-1:0] pos
);
   localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

   logic dir_up;

   // Turning around moves one step back immediately, so the end positions are held for one frame only.
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         pos    <= '0;
         dir_up <= 1'b1;
      end else if (step) begin
         if (dir_up) begin
            if (pos == LIM) begin
               dir_up <= 1'b0;
               pos    <= LIM - 1'b1;
            end else begin
               pos <= pos + 1'b1;
            end
         end else begin
            if (pos == '0) begin
               dir_up <= 1'b1;
               pos    <= WIDTH'(1);
            end else begin
               pos <= pos - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/test_pattern_gen.sv
// rtl/test_pattern_gen.sv - two-stage HDMI test pattern source with frame-synchronous mode switching
module test_pattern_gen
   import pattern_pkg::*;
#(
   parameter int HACTIVE  = 1280,
   parameter int VACTIVE  = 720,
   parameter int COORD_W  = 11,
   parameter int BOX_SIZE = 64
) (
   input  logic               pix_clk,
   input  logic               reset_n,
   input  logic [1:0]         mode,
   input  logic [COORD_W-1:0] row,
   input  logic [COORD_W-1:0] column,
   output logic [7:0]         r,
   output logic [7:0]         g,
   output logic [7:0]         b,
   output logic               frame_start
);
   localparam int               BAR_W   = HACTIVE / 8;
   localparam logic [COORD_W:0] BOX_EXT = (COORD_W+1)'(BOX_SIZE);

   logic [COORD_W-1:0] prev_row, prev_col;
   logic               frame_det, blank;
   logic [2:0]         bar_idx;
   rgb_t               grad;

   logic [COORD_W-1:0] row_q, col_q;
   logic               blank_q, det_q, chk_q;
   rgb_t               grad_q, bar_q;

   pattern_mode_e      mode_q;
   logic [7:0]         frame_cnt;
   logic [COORD_W-1:0] box_x, box_y;

   logic               in_box;
   rgb_t               pix, pix_q;
   logic               frame_start_q;

   // ---------------- stage 1 ----------------
   assign frame_det = (row == '0) && (column == '0) && !((prev_row == '0) && (prev_col == '0));
   assign blank     = (row >= COORD_W'(VACTIVE)) || (column >= COORD_W'(HACTIVE));

   always_comb begin
      grad.r = row[7:0];
      grad.g = column[7:0];
      grad.b = 8'd255 - {1'b0, row[7:1]} - {1'b0, column[7:1]};
   end

   // Bar index from a ladder of threshold comparators rather than a divide.
   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < 8; k++) begin
         if (column >= COORD_W'(k * BAR_W)) bar_idx = 3'(k);
      end
   end

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_row <= '1;
         prev_col <= '1;
         row_q    <= '0;
         col_q    <= '0;
         blank_q  <= 1'b1;
         det_q    <= 1'b0;
         chk_q    <= 1'b0;
         grad_q   <= '0;
         bar_q    <= '0;
      end else begin
         prev_row <= row;
         prev_col <= column;
         row_q    <= row;
         col_q    <= column;
         blank_q  <= blank;
         det_q    <= frame_det;
         chk_q    <= row[5] ^ column[5];
         grad_q   <= grad;
         bar_q    <= bar_color(bar_idx);
      end
   end

   // Frame state updates on the detect edge, so stage 2 of pixel (0,0) already sees it.
   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q    <= GRADIENT;
         frame_cnt <= '0;
      end else if (frame_det) begin
         mode_q    <= pattern_mode_e'(mode);
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   box_axis #(.LIMIT(HACTIVE - BOX_SIZE), .WIDTH(COORD_W)) u_box_x (
      .pix_clk (pix_clk),
      .reset_n (reset_n),
      .step    (frame_det),
      .pos     (box_x)
   );

   box_axis #(.LIMIT(VACTIVE - BOX_SIZE), .WIDTH(COORD_W)) u_box_y (
      .pix_clk (pix_clk),
      .reset_n (reset_n),
      .step    (frame_det),
      .pos     (box_y)
   );

   // ---------------- stage 2 ----------------
   always_comb begin
      pix    = '0;
      in_box = ({1'b0, col_q} >= {1'b0, box_x}) && ({1'b0, col_q} < ({1'b0, box_x} + BOX_EXT)) &&
               ({1'b0, row_q} >= {1'b0, box_y}) && ({1'b0, row_q} < ({1'b0, box_y} + BOX_EXT));
      if (!blank_q) begin
         case (mode_q)
            GRADIENT: pix = grad_q;
            BARS:     pix = bar_q;
            CHECKER:  pix = (chk_q ^ frame_cnt[5]) ? rgb_t'(C_WHITE) : rgb_t'(C_BLACK);
            BOX:      pix = in_box ? rgb_t'(C_WHITE) : rgb_t'(C_BOX_BG);
            default:  pix = '0;
         endcase
      end
   end

   always_ff @(posedge pix_clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_q         <= '0;
         frame_start_q <= 1'b0;
      end else begin
         pix_q         <= pix;
         frame_start_q <= det_q;
      end
   end

   assign r           = pix_q.r;
   assign g           = pix_q.g;
   assign b           = pix_q.b;
   assign frame_start = frame_start_q;

endmodule
